// File: rtl/mips_data_responder_pkg.sv
// Shared bus definitions for the MIPS data-memory responder.
// FSM encodings, data segment base and bus width.
package mips_data_responder_pkg;

    localparam int BUS_W = 32;
    localparam logic [31:0] DATA_SEG_BASE = 32'h1001_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mips_data_ram.sv
// Single-port word RAM, synchronous write, registered read.
// Contents are deliberately not reset.
module mips_data_ram
    import mips_data_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [BUS_W-1:0] wdata,
    output logic [BUS_W-1:0] rdata
);

    logic [BUS_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mips_data_responder.sv
// Data-memory responder: one request at a time, fixed wait states,
// then read data or write acknowledge with an error flag.
module mips_data_responder
    import mips_data_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = DATA_SEG_BASE,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [BUS_W-1:0] req_addr,
    input  logic [BUS_W-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [BUS_W-1:0] rsp_rdata,
    output logic             rsp_error
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

    state_t           state;
    state_t           state_n;
    logic [3:0]       cnt;
    logic             wr_q;
    logic             err_q;
    logic [IDX_W-1:0] idx_q;
    logic [BUS_W-1:0] wdata_q;

    logic [31:0]      off;
    logic [IDX_W-1:0] req_idx;
    logic             req_err;
    logic             accept;
    logic             access;
    logic             ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [BUS_W-1:0] ram_rdata;

    always_comb begin
        off     = req_addr - BASE_ADDR;
        req_idx = off[IDX_W+1:2];
        req_err = (req_addr[1:0] != 2'b00)
                  || (req_addr < BASE_ADDR)
                  || (off >= SPAN);
        accept  = (state == IDLE) && req_ready && req_valid;
        access  = (state == WAIT) && (cnt == 4'd0);
        ram_we  = access && wr_q && !err_q;
        // Address the RAM from the live request while idle so the
        // registered read is already settled by the access cycle.
        ram_addr = (state == IDLE) ? req_idx : idx_q;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = WAIT;
            WAIT:    if (cnt == 4'd0) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        wr_q      <= req_write;
                        err_q     <= req_err;
                        idx_q     <= req_idx;
                        wdata_q   <= req_wdata;
                        cnt       <= 4'(WAIT_CYCLES);
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= err_q;
                        rsp_rdata <= (!wr_q && !err_q) ? ram_rdata : '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_error <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mips_data_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (IDX_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_mips_data_responder.sv
// Scoreboard bench for mips_data_responder (WAIT_CYCLES=2 and =0 builds).
module tb_mips_data_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        rv [2];
    logic        rw [2];
    logic        rr [2];
    logic        qr [2];
    logic        sv [2];
    logic        se [2];
    logic [31:0] ra [2];
    logic [31:0] rwd[2];
    logic [31:0] sd [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total = 0;
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];

    mips_data_responder #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(rv[0]), .req_ready(qr[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_wdata(rwd[0]),
        .rsp_valid(sv[0]), .rsp_ready(rr[0]),
        .rsp_rdata(sd[0]), .rsp_error(se[0])
    );

    mips_data_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(rv[1]), .req_ready(qr[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_wdata(rwd[1]),
        .rsp_valid(sv[1]), .rsp_ready(rr[1]),
        .rsp_rdata(sd[1]), .rsp_error(se[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic push(input int d, input logic [32:0] e);
        if (d == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic mon(input int d);
        logic [32:0] e;
        int n;
        n = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (n == 0) begin
            total++;
            $display("FAIL rsp_unexpected dut%0d: got rdata %h, want none",
                     d, sd[d]);
        end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("rsp_rdata dut%0d", d), sd[d], e[31:0]);
            chk($sformatf("rsp_error dut%0d", d), {31'b0, se[d]},
                {31'b0, e[32]});
        end
    endtask

    always @(negedge clk) if (!reset && sv[0] && rr[0]) mon(0);
    always @(negedge clk) if (!reset && sv[1] && rr[1]) mon(1);

    task automatic wait_ready(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (qr[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_req(input int d, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input bit exp_err, input int lat);
        bit ok;
        int t0;
        @(negedge clk);
        rv[d] = 1'b1; rw[d] = wr; ra[d] = a; rwd[d] = wd; rr[d] = 1'b1;
        push(d, {exp_err, exp_rd});
        wait_ready(d, ok);
        if (!ok) begin
            total++;
            $display("FAIL accept dut%0d: req_ready never 1, want 1", d);
            rv[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        t0 = cyc;
        rv[d] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sv[d]) break;
        end
        chk($sformatf("latency dut%0d @%h", d, a), 32'(cyc - t0), 32'(lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int t0;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; rw[d] = 1'b0; rr[d] = 1'b0;
            ra[d] = '0; rwd[d] = '0;
        end
        repeat (2) @(negedge clk);
        chk("reset req_ready", {31'b0, qr[0]}, 32'd0);
        chk("reset rsp_valid", {31'b0, sv[0]}, 32'd0);
        chk("reset rsp_rdata", sd[0], 32'd0);
        chk("reset rsp_error", {31'b0, se[0]}, 32'd0);
        reset = 1'b0;
        #1;
        chk("req_ready before first edge", {31'b0, qr[0]}, 32'd0);
        @(posedge clk);
        #1;
        chk("req_ready after first edge", {31'b0, qr[0]}, 32'd1);

        do_req(0, 1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0, 0, 3);
        do_req(0, 0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 0, 3);
        do_req(0, 1, 32'h1001_0000, 32'h1111_1111, 32'h0, 0, 3);
        do_req(0, 0, 32'h1001_0002, 32'h0, 32'h0, 1, 3);
        do_req(0, 1, 32'h1001_0402, 32'hBAD0_BAD0, 32'h0, 1, 3);
        do_req(0, 0, 32'h1001_0000, 32'h0, 32'h1111_1111, 0, 3);
        do_req(0, 0, 32'h1000_FFFC, 32'h0, 32'h0, 1, 3);
        do_req(0, 0, 32'h1001_0400, 32'h0, 32'h0, 1, 3);
        do_req(0, 1, 32'h1001_03FC, 32'hA5A5_A5A5, 32'h0, 0, 3);
        do_req(0, 0, 32'h1001_03FC, 32'h0, 32'hA5A5_A5A5, 0, 3);

        // Response back-pressure with a pending request behind it.
        @(negedge clk);
        rr[0] = 1'b0; rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h1001_0004;
        push(0, {1'b0, 32'hDEAD_BEEF});
        wait_ready(0, ok);
        @(posedge clk);
        #1;
        ra[0] = 32'h1001_03FC;
        push(0, {1'b0, 32'hA5A5_A5A5});
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sv[0]) break;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold rsp_valid", {31'b0, sv[0]}, 32'd1);
            chk("hold rsp_rdata", sd[0], 32'hDEAD_BEEF);
            chk("hold rsp_error", {31'b0, se[0]}, 32'd0);
            chk("hold req_ready", {31'b0, qr[0]}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rr[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("release rsp_valid", {31'b0, sv[0]}, 32'd0);
        chk("release rsp_rdata", sd[0], 32'd0);
        chk("release req_ready", {31'b0, qr[0]}, 32'd1);
        @(posedge clk);
        #1;
        chk("pending accepted", {31'b0, qr[0]}, 32'd0);
        t0 = cyc;
        rv[0] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sv[0]) break;
        end
        chk("pending latency", 32'(cyc - t0), 32'd3);
        @(posedge clk);
        #1;

        // Reset in WAIT discards an uncommitted store.
        do_req(0, 1, 32'h1001_0008, 32'hCAFE_F00D, 32'h0, 0, 3);
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h1001_0008;
        rwd[0] = 32'h1234_5678;
        wait_ready(0, ok);
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("wait reset rsp_valid", {31'b0, sv[0]}, 32'd0);
        chk("wait reset req_ready", {31'b0, qr[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_req(0, 0, 32'h1001_0008, 32'h0, 32'hCAFE_F00D, 0, 3);

        // Reset in RESP clears the outputs without waiting for a clock.
        @(negedge clk);
        rr[0] = 1'b0; rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h1001_0400;
        wait_ready(0, ok);
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sv[0]) break;
        end
        chk("resp before reset error", {31'b0, se[0]}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("resp reset rsp_valid", {31'b0, sv[0]}, 32'd0);
        chk("resp reset rsp_error", {31'b0, se[0]}, 32'd0);
        chk("resp reset rsp_rdata", sd[0], 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_req(1, 1, 32'h1001_0010, 32'h0BAD_CAFE, 32'h0, 0, 1);
        do_req(1, 0, 32'h1001_0010, 32'h0, 32'h0BAD_CAFE, 0, 1);
        do_req(1, 0, 32'h1001_0011, 32'h0, 32'h0, 1, 1);
        do_req(1, 0, 32'h1001_0010, 32'h0, 32'h0BAD_CAFE, 0, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard drained dut0", 32'(exp_q0.size()), 32'd0);
        chk("scoreboard drained dut1", 32'(exp_q1.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1, "watchdog");
    end

endmodule
